histogram_clip_finder: RTL and testbench

- Downstream consumer of the Histogram stage.
- After a frame's histogram is complete, scans the bin RAM once from bin 0 to bin 2^DATA_WIDTH-1 and accumulates a cumulative count.
- Reports the first bins where the cumulative count reaches programmable low and high thresholds.
- Results feed the contrast-stretch LUT as its black and white clip points.

---
 rtl/histogram_clip_finder.sv | 161 ++++++++++++++++
 tb/tb_histogram_clip_finder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_clip_finder.sv
// Scans a completed histogram once and reports the first bins where the running
// count reaches the low and high clip thresholds (black/white clip points).
module histogram_clip_finder #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [CNT_WIDTH-1:0]  LowCnt,
    input  logic [CNT_WIDTH-1:0]  HighCnt,
    output logic                  BinRdEn,
    output logic [DATA_WIDTH-1:0] BinAddr,
    input  logic [CNT_WIDTH-1:0]  BinData,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] LowBin,
    output logic [DATA_WIDTH-1:0] HighBin
);

    localparam logic [DATA_WIDTH-1:0] LAST_BIN = {DATA_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] bin_k_q, bin_k_d;
    logic [CNT_WIDTH-1:0]  cum_q, cum_d;
    logic [CNT_WIDTH-1:0]  low_thr_q, low_thr_d;
    logic [CNT_WIDTH-1:0]  high_thr_q, high_thr_d;
    logic                  low_found_q, low_found_d;
    logic                  high_found_q, high_found_d;
    logic [DATA_WIDTH-1:0] low_res_q, low_res_d;
    logic [DATA_WIDTH-1:0] high_res_q, high_res_d;
    logic [DATA_WIDTH-1:0] low_bin_q, low_bin_d;
    logic [DATA_WIDTH-1:0] high_bin_q, high_bin_d;

    logic [CNT_WIDTH:0]    cum_sum;
    logic [CNT_WIDTH-1:0]  cum_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            valid_q      <= 1'b0;
            bin_k_q      <= '0;
            cum_q        <= '0;
            low_thr_q    <= '0;
            high_thr_q   <= '0;
            low_found_q  <= 1'b0;
            high_found_q <= 1'b0;
            low_res_q    <= LAST_BIN;
            high_res_q   <= LAST_BIN;
            low_bin_q    <= '0;
            high_bin_q   <= LAST_BIN;
        end else begin
            state_q      <= state_d;
            rd_en_q      <= rd_en_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            bin_k_q      <= bin_k_d;
            cum_q        <= cum_d;
            low_thr_q    <= low_thr_d;
            high_thr_q   <= high_thr_d;
            low_found_q  <= low_found_d;
            high_found_q <= high_found_d;
            low_res_q    <= low_res_d;
            high_res_q   <= high_res_d;
            low_bin_q    <= low_bin_d;
            high_bin_q   <= high_bin_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_en_d      = rd_en_q;
        addr_d       = addr_q;
        valid_d      = rd_en_q;
        bin_k_d      = addr_q;
        cum_d        = cum_q;
        low_thr_d    = low_thr_q;
        high_thr_d   = high_thr_q;
        low_found_d  = low_found_q;
        high_found_d = high_found_q;
        low_res_d    = low_res_q;
        high_res_d   = high_res_q;
        low_bin_d    = low_bin_q;
        high_bin_d   = high_bin_q;

        // Saturating accumulate so a huge bin can never wrap into a false later hit.
        cum_sum  = {1'b0, cum_q} + {1'b0, BinData};
        cum_next = cum_sum[CNT_WIDTH] ? CNT_MAX : cum_sum[CNT_WIDTH-1:0];

        if (valid_q) begin
            cum_d = cum_next;
            if (!low_found_q && (cum_next >= low_thr_q)) begin
                low_found_d = 1'b1;
                low_res_d   = bin_k_q;
            end
            if (!high_found_q && (cum_next >= high_thr_q)) begin
                high_found_d = 1'b1;
                high_res_d   = bin_k_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d      = READ;
                    rd_en_d      = 1'b1;
                    addr_d       = '0;
                    low_thr_d    = LowCnt;
                    high_thr_d   = HighCnt;
                    cum_d        = '0;
                    low_found_d  = 1'b0;
                    high_found_d = 1'b0;
                    low_res_d    = LAST_BIN;
                    high_res_d   = LAST_BIN;
                end
            end
            READ: begin
                if (addr_q == LAST_BIN) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // Results default to the last bin, so unmet thresholds report N-1.
                state_d    = DONE;
                low_bin_d  = low_res_d;
                high_bin_d = high_res_d;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign BinRdEn = rd_en_q;
    assign BinAddr = addr_q;
    assign Busy    = (state_q != IDLE);
    assign Done    = (state_q == DONE);
    assign LowBin  = low_bin_q;
    assign HighBin = high_bin_q;

endmodule

// File: tb/tb_histogram_clip_finder.sv
// Directed bench for histogram_clip_finder: a bin RAM model answers reads one
// cycle later, and each scenario task checks clip points, timing and control.
module tb_histogram_clip_finder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [17:0] low_cnt;
    logic [17:0] high_cnt;
    logic        bin_rd_en;
    logic [7:0]  bin_addr;
    logic [17:0] bin_data;
    logic        busy;
    logic        done;
    logic [7:0]  low_bin;
    logic [7:0]  high_bin;

    logic [17:0] mem [0:255];

    int checks;
    int failures;

    histogram_clip_finder #(.DATA_WIDTH(8), .CNT_WIDTH(18)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Start   (start),
        .LowCnt  (low_cnt),
        .HighCnt (high_cnt),
        .BinRdEn (bin_rd_en),
        .BinAddr (bin_addr),
        .BinData (bin_data),
        .Busy    (busy),
        .Done    (done),
        .LowBin  (low_bin),
        .HighBin (high_bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bin RAM model: one-cycle read latency.
    initial bin_data = '0;
    always @(posedge clk) begin
        if (bin_rd_en) bin_data <= mem[bin_addr];
    end

    task automatic load_basic_hist();
        for (int i = 0; i < 256; i++) mem[i] = 18'd0;
        mem[0] = 18'd2; mem[1] = 18'd3; mem[2] = 18'd2; mem[3] = 18'd1;
        mem[4] = 18'd2; mem[5] = 18'd3; mem[6] = 18'd4;
    endtask

    // Drives one Start and observes the scan; returns at the negedge of Done.
    task automatic run_scan(input logic [17:0] lo, input logic [17:0] hi,
                            input int mid_start_at, input int reset_at,
                            output int done_cycle, output int done_count,
                            output bit addr_ok, output bit stable_ok,
                            output bit busy_ok,
                            output logic [7:0] lb, output logic [7:0] hb);
        logic [7:0] prev_lb;
        logic [7:0] prev_hb;
        done_cycle = -1;
        done_count = 0;
        addr_ok    = 1'b1;
        stable_ok  = 1'b1;
        busy_ok    = 1'b1;
        lb         = 'x;
        hb         = 'x;
        @(negedge clk);
        prev_lb  = low_bin;
        prev_hb  = high_bin;
        start    = 1'b1;
        low_cnt  = lo;
        high_cnt = hi;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == mid_start_at) start = 1'b1;
            if (c == mid_start_at + 1) start = 1'b0;
            if (c == reset_at) rst_n = 1'b0;
            if (c <= 256) begin
                if (bin_rd_en !== 1'b1 || bin_addr !== 8'(c - 1)) addr_ok = 1'b0;
            end else if (c == 257) begin
                if (bin_rd_en !== 1'b0) addr_ok = 1'b0;
            end
            if (done === 1'b1) begin
                done_count++;
                done_cycle = c;
                lb = low_bin;
                hb = high_bin;
                if (busy !== 1'b1) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (low_bin !== prev_lb || high_bin !== prev_hb) stable_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (bin_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_rden: got %b expected 0", bin_rd_en); end
        checks++;
        if (bin_addr !== 8'd0) begin failures++; $display("[TB] FAIL reset_addr: got %0d expected 0", bin_addr); end
        checks++;
        if (low_bin !== 8'd0) begin failures++; $display("[TB] FAIL reset_lowbin: got %0d expected 0", low_bin); end
        checks++;
        if (high_bin !== 8'd255) begin failures++; $display("[TB] FAIL reset_highbin: got %0d expected 255", high_bin); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dc, dn;
        bit a_ok, s_ok, b_ok;
        logic [7:0] lb, hb;
        load_basic_hist();
        run_scan(18'd5, 18'd14, -1, -1, dc, dn, a_ok, s_ok, b_ok, lb, hb);
        checks++;
        if (dc !== 258) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected 258", dc); end
        checks++;
        if (a_ok !== 1'b1) begin failures++; $display("[TB] FAIL basic_addr_seq: got %b expected 1", a_ok); end
        checks++;
        if (s_ok !== 1'b1) begin failures++; $display("[TB] FAIL basic_output_stable: got %b expected 1", s_ok); end
        checks++;
        if (b_ok !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy: got %b expected 1", b_ok); end
        checks++;
        if (lb !== 8'd1) begin failures++; $display("[TB] FAIL basic_lowbin: got %0d expected 1", lb); end
        checks++;
        if (hb !== 8'd6) begin failures++; $display("[TB] FAIL basic_highbin: got %0d expected 6", hb); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_after_done: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_boundary();
        int dc, dn;
        bit a_ok, s_ok, b_ok;
        logic [7:0] lb, hb;
        load_basic_hist();
        run_scan(18'd0, 18'd17, -1, -1, dc, dn, a_ok, s_ok, b_ok, lb, hb);
        checks++;
        if (lb !== 8'd0) begin failures++; $display("[TB] FAIL bound_low_zero: got %0d expected 0", lb); end
        checks++;
        if (hb !== 8'd6) begin failures++; $display("[TB] FAIL bound_high_total: got %0d expected 6", hb); end
        run_scan(18'd0, 18'd18, -1, -1, dc, dn, a_ok, s_ok, b_ok, lb, hb);
        checks++;
        if (hb !== 8'd255) begin failures++; $display("[TB] FAIL bound_high_unmet: got %0d expected 255", hb); end
        checks++;
        if (lb !== 8'd0) begin failures++; $display("[TB] FAIL bound_low_zero2: got %0d expected 0", lb); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int dc, dn;
        bit a_ok, s_ok, b_ok;
        logic [7:0] lb, hb;
        load_basic_hist();
        run_scan(18'd13, 18'd13, -1, -1, dc, dn, a_ok, s_ok, b_ok, lb, hb);
        checks++;
        if (lb !== 8'd5 || hb !== 8'd5) begin
            failures++;
            $display("[TB] FAIL simultaneous: got low=%0d high=%0d expected 5 5", lb, hb);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int dc, dn;
        bit a_ok, s_ok, b_ok;
        logic [7:0] lb, hb;
        for (int i = 0; i < 256; i++) mem[i] = 18'd0;
        mem[0] = 18'h3FFFF;
        mem[1] = 18'h3FFFF;
        run_scan(18'h3FFFF, 18'h3FFFF, -1, -1, dc, dn, a_ok, s_ok, b_ok, lb, hb);
        checks++;
        if (lb !== 8'd0 || hb !== 8'd0) begin
            failures++;
            $display("[TB] FAIL sat_bin0: got low=%0d high=%0d expected 0 0", lb, hb);
        end
        @(negedge clk);
        // 262140 + 262143 saturates at bin 1; a wrapping adder would never reach max.
        mem[0] = 18'd262140;
        mem[1] = 18'h3FFFF;
        run_scan(18'd262141, 18'h3FFFF, -1, -1, dc, dn, a_ok, s_ok, b_ok, lb, hb);
        checks++;
        if (lb !== 8'd1 || hb !== 8'd1) begin
            failures++;
            $display("[TB] FAIL sat_no_wrap: got low=%0d high=%0d expected 1 1", lb, hb);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_start();
        int dc, dn;
        bit a_ok, s_ok, b_ok;
        logic [7:0] lb, hb;
        load_basic_hist();
        run_scan(18'd5, 18'd14, 101, -1, dc, dn, a_ok, s_ok, b_ok, lb, hb);
        checks++;
        if (dc !== 258) begin failures++; $display("[TB] FAIL midstart_latency: got %0d expected 258", dc); end
        checks++;
        if (a_ok !== 1'b1) begin failures++; $display("[TB] FAIL midstart_addr_seq: got %b expected 1", a_ok); end
        checks++;
        if (lb !== 8'd1 || hb !== 8'd6) begin
            failures++;
            $display("[TB] FAIL midstart_result: got low=%0d high=%0d expected 1 6", lb, hb);
        end
        // A wrongly accepted second Start would show up as extra activity here.
        dn = 0;
        for (int c = 0; c < 270; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        checks++;
        if (dn !== 0) begin failures++; $display("[TB] FAIL midstart_extra_activity: got %0d cycles expected 0", dn); end
    endtask

    task automatic test_reset_mid_scan();
        int dc, dn;
        bit a_ok, s_ok, b_ok;
        logic [7:0] lb, hb;
        load_basic_hist();
        run_scan(18'd5, 18'd14, -1, 51, dc, dn, a_ok, s_ok, b_ok, lb, hb);
        checks++;
        if (dn !== 0) begin failures++; $display("[TB] FAIL rstmid_no_done: got %0d dones expected 0", dn); end
        checks++;
        if (busy !== 1'b0 || bin_rd_en !== 1'b0 || bin_addr !== 8'd0) begin
            failures++;
            $display("[TB] FAIL rstmid_ctrl: got busy=%b rden=%b addr=%0d expected 0 0 0", busy, bin_rd_en, bin_addr);
        end
        checks++;
        if (low_bin !== 8'd0 || high_bin !== 8'd255) begin
            failures++;
            $display("[TB] FAIL rstmid_outputs: got low=%0d high=%0d expected 0 255", low_bin, high_bin);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dc, dn;
        bit a_ok, s_ok, b_ok;
        logic [7:0] lb, hb;
        load_basic_hist();
        run_scan(18'd5, 18'd14, -1, -1, dc, dn, a_ok, s_ok, b_ok, lb, hb);
        checks++;
        if (dc !== 258 || a_ok !== 1'b1 || lb !== 8'd1 || hb !== 8'd6) begin
            failures++;
            $display("[TB] FAIL clean_scan: got dc=%0d addr_ok=%b low=%0d high=%0d expected 258 1 1 6", dc, a_ok, lb, hb);
        end
        run_scan(18'd13, 18'd18, -1, -1, dc, dn, a_ok, s_ok, b_ok, lb, hb);
        checks++;
        if (dc !== 258) begin failures++; $display("[TB] FAIL b2b_latency: got %0d expected 258", dc); end
        checks++;
        if (s_ok !== 1'b1) begin failures++; $display("[TB] FAIL b2b_output_stable: got %b expected 1", s_ok); end
        checks++;
        if (lb !== 8'd5 || hb !== 8'd255) begin
            failures++;
            $display("[TB] FAIL b2b_result: got low=%0d high=%0d expected 5 255", lb, hb);
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        low_cnt  = '0;
        high_cnt = '0;
        for (int i = 0; i < 256; i++) mem[i] = 18'd0;
        test_reset();
        test_basic();
        test_boundary();
        test_simultaneous();
        test_saturation();
        test_mid_start();
        test_reset_mid_scan();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
